axi_isolate_pwr_seq: RTL
========================

Name: axi_isolate_pwr_seq

Overview:
Power/isolation sequencer that sits directly upstream of the AXI isolation stage. It drives that stage's isolate input and consumes its isolated output. On a sleep request it isolates the AXI master port, then asserts the domain reset, then hands off to the power manager with a 4-phase req/ack. Wake-up runs the same steps in reverse, with a settle delay, and includes timeout supervision.

Parameters:
TimeoutCycles, 1024, max cycles in Isolating/PowerDown/PowerUp before the timeout flag is set; must be >0.
SettleCycles, 16, cycles after power ack before the domain reset is released; must be >0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
sleep_req_i  in  1  level: 1 = domain should be off
awake_o  out  1  state==Active
asleep_o  out  1  state==Off
timeout_o  out  1  sticky timeout flag
clr_timeout_i  in  1  clears timeout_o
isolate_o  out  1  to isolate_i of the AXI isolation stage
isolated_i  in  1  from isolated_o of the AXI isolation stage
pwr_on_req_o  out  1  4-phase power request, 1 = power on
pwr_on_ack_i  in  1  power manager ack, follows req
rst_dom_no  out  1  domain reset, active low

Behaviour:
- Clock and reset: one clock, clk_i; rst_ni is synchronous, active-low.
- Outputs: all Moore-decoded from the state register only; no combinational path from any input to any output.
- Reset:
  - state=Off, counter=0, timeout_o=0.
  - Hence isolate_o=1, pwr_on_req_o=0, rst_dom_no=0, asleep_o=1, awake_o=0.
  - Reset mid-sequence returns to Off at the next edge, with no intermediate states.
- Output levels per state (isolate_o / pwr_on_req_o / rst_dom_no):
  - Active 0/1/1.
  - Isolating 1/1/1.
  - PowerDown 1/0/0.
  - Off 1/0/0.
  - PowerUp 1/1/0.
  - Settle 1/1/0.
  - Release 0/1/1.
- Transitions:
  - Active: sleep_req_i -> Isolating.
  - Isolating:
    - isolated_i -> PowerDown. Precedence: isolated_i, then !sleep_req_i, then timeout.
    - else !sleep_req_i -> Release (cancel).
    - else cnt==TimeoutCycles-1 -> set timeout, Release (abort; power is never cut with transactions pending). Exactly TimeoutCycles cycles are spent in Isolating before the abort.
  - PowerDown: !pwr_on_ack_i -> Off. At cnt==TimeoutCycles-1, set timeout and keep waiting.
  - Off: !sleep_req_i -> PowerUp.
  - PowerUp: pwr_on_ack_i -> Settle. Timeout sets the flag and keeps waiting.
  - Settle: cnt==SettleCycles-1 -> Release. The domain reset stays low for exactly SettleCycles cycles after ack is seen.
  - Release: !isolated_i -> Active. Minimum 1 cycle, because the isolation stage registers its state.
- sleep_req_i is sampled only in Active, Isolating and Off; it is ignored in PowerDown, PowerUp, Settle and Release.
- Counter:
  - Width $clog2(max(TimeoutCycles,SettleCycles)+1).
  - Cleared on every state change; increments otherwise; saturates at max and never wraps.
- timeout_o: set and clear in the same cycle -> set wins. The flag is not cleared by state changes.
- Handshake rule: pwr_on_req_o changes only in PowerDown entry (->0) and PowerUp entry (->1). It never toggles while req != ack.

Optional Feature:
- Macro AXI_ISOLATE_PWR_SEQ_FORCE_EN.
- Defined:
  - Adds port force_i (in, 1).
  - At the Isolating timeout with force_i=1: set timeout, go to PowerDown (forced power-off despite pending transactions) instead of Release.
- Undefined: the port is absent and a timeout in Isolating always aborts to Release.

Decomposition:
- Package axi_isolate_pwr_pkg:
  - State enum pwr_seq_state_e, 3 bits: Active, Isolating, PowerDown, Off, PowerUp, Settle, Release.
  - Function computing the counter width.
- One sub-module, axi_isolate_pwr_cnt: saturating counter with clear; its parameter is the width.
- FSM and output decode live in the top module.

Test Plan (TimeoutCycles=8, SettleCycles=4):
- Power-up from reset: release reset with sleep_req_i=0; ack rises 2 cycles after req.
  - PowerUp, then Settle held exactly 4 cycles.
  - Then rst_dom_no=1 and isolate_o=0.
  - isolated_i falls 1 cycle later -> awake_o=1.
- Clean sleep: from Active, sleep_req_i=1; isolated_i rises after 3 cycles.
  - Next cycle PowerDown: pwr_on_req_o=0, rst_dom_no=0.
  - ack falls 2 cycles later -> asleep_o=1, timeout_o=0.
- Isolation timeout: sleep_req_i=1, isolated_i held 0.
  - After 8 cycles in Isolating: timeout_o=1, state Release, then Active.
  - pwr_on_req_o stays 1 throughout. With FORCE_EN and force_i=1, PowerDown is entered instead.
- Cancel: sleep_req_i drops in the 2nd Isolating cycle -> Release, then Active; timeout_o=0.
- Sticky flag:
  - clr_timeout_i=1 in the same cycle as a timeout -> timeout_o stays 1.
  - clr_timeout_i=1 the next cycle -> timeout_o=0.
- Reset mid-sequence: assert rst_ni=0 during Settle -> next edge: isolate_o=1, pwr_on_req_o=0, rst_dom_no=0, asleep_o=1.

Source files
------------

// File: rtl/axi_isolate_pwr_pkg.sv
// Shared types and helpers for the AXI isolation power sequencer.
package axi_isolate_pwr_pkg;

    typedef enum logic [2:0] {
        ST_ACTIVE    = 3'd0,
        ST_ISOLATING = 3'd1,
        ST_POWERDOWN = 3'd2,
        ST_OFF       = 3'd3,
        ST_POWERUP   = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_RELEASE   = 3'd6
    } pwr_seq_state_e;

    // Counter must hold the larger of the two dwell limits.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles,
                                              input int unsigned settle_cycles);
        int unsigned max_v;
        max_v = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/axi_isolate_pwr_cnt.sv
// Saturating dwell counter with synchronous clear.
module axi_isolate_pwr_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/axi_isolate_pwr_seq.sv
// Isolate -> reset -> power-off sequencer (and the reverse on wake-up) in front of the AXI isolation stage.
// Optional forced power-off on isolation timeout: define AXI_ISOLATE_PWR_SEQ_FORCE_EN (adds force_i).
module axi_isolate_pwr_seq
    import axi_isolate_pwr_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned SettleCycles  = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sleep_req_i,
    output logic awake_o,
    output logic asleep_o,
    output logic timeout_o,
    input  logic clr_timeout_i,
`ifdef AXI_ISOLATE_PWR_SEQ_FORCE_EN
    input  logic force_i,
`endif
    output logic isolate_o,
    input  logic isolated_i,
    output logic pwr_on_req_o,
    input  logic pwr_on_ack_i,
    output logic rst_dom_no
);

    localparam int unsigned CntW = cnt_width(TimeoutCycles, SettleCycles);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles - 1);

    pwr_seq_state_e    r_state;
    pwr_seq_state_e    w_state_nxt;
    logic              w_set_timeout;
    logic              w_state_chg;
    logic [CntW-1:0]   w_cnt;
    logic              r_timeout;

    assign w_state_chg = (w_state_nxt != r_state);

    axi_isolate_pwr_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_state_chg),
        .cnt_o  (w_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sticky flag: a new timeout beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
        end else if (clr_timeout_i) begin
            r_timeout <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (sleep_req_i) w_state_nxt = ST_ISOLATING;
            end
            ST_ISOLATING: begin
                if (isolated_i) begin
                    w_state_nxt = ST_POWERDOWN;
                end else if (!sleep_req_i) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_cnt == TimeoutLast) begin
                    w_set_timeout = 1'b1;
`ifdef AXI_ISOLATE_PWR_SEQ_FORCE_EN
                    w_state_nxt   = force_i ? ST_POWERDOWN : ST_RELEASE;
`else
                    w_state_nxt   = ST_RELEASE;
`endif
                end
            end
            ST_POWERDOWN: begin
                if (!pwr_on_ack_i) begin
                    w_state_nxt = ST_OFF;
                end else if (w_cnt == TimeoutLast) begin
                    w_set_timeout = 1'b1;
                end
            end
            ST_OFF: begin
                if (!sleep_req_i) w_state_nxt = ST_POWERUP;
            end
            ST_POWERUP: begin
                if (pwr_on_ack_i) begin
                    w_state_nxt = ST_SETTLE;
                end else if (w_cnt == TimeoutLast) begin
                    w_set_timeout = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_cnt == SettleLast) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!isolated_i) w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Moore decode from the state register only.
    always_comb begin
        isolate_o    = 1'b1;
        pwr_on_req_o = 1'b0;
        rst_dom_no   = 1'b0;
        awake_o      = 1'b0;
        asleep_o     = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                isolate_o    = 1'b0;
                pwr_on_req_o = 1'b1;
                rst_dom_no   = 1'b1;
                awake_o      = 1'b1;
            end
            ST_ISOLATING: begin
                pwr_on_req_o = 1'b1;
                rst_dom_no   = 1'b1;
            end
            ST_OFF: begin
                asleep_o = 1'b1;
            end
            ST_POWERUP, ST_SETTLE: begin
                pwr_on_req_o = 1'b1;
            end
            ST_RELEASE: begin
                isolate_o    = 1'b0;
                pwr_on_req_o = 1'b1;
                rst_dom_no   = 1'b1;
            end
            default: begin
                isolate_o = 1'b1;
            end
        endcase
    end

    assign timeout_o = r_timeout;

endmodule
